// File: rtl/abs_unit.sv
// abs_unit: registered two's-complement absolute value with sign and most-negative flag.
// Build option: define ABS_SATURATE_EN to clamp the most-negative input to 0111...1.
module abs_unit #(
  parameter int NUM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [NUM_WIDTH-1:0] ans,
  output logic [NUM_WIDTH-1:0] abs_ans,
  output logic                 out_valid,
  output logic                 sign_out,
  output logic                 ovf
);

  localparam logic [NUM_WIDTH-1:0] ONE = NUM_WIDTH'(1);
`ifdef ABS_SATURATE_EN
  localparam logic [NUM_WIDTH-1:0] MAX_POS = {1'b0, {(NUM_WIDTH-1){1'b1}}};
`endif

  logic                 msb;
  logic                 mostNeg;
  logic [NUM_WIDTH-1:0] magnitude;
  logic [NUM_WIDTH-1:0] abs_d, abs_q;
  logic                 sign_d, sign_q;
  logic                 ovf_d, ovf_q;
  logic                 valid_d, valid_q;

  // The negate wraps 1000...0 onto itself, which read as unsigned is still the true magnitude.
  always_comb begin
    msb       = ans[NUM_WIDTH-1];
    mostNeg   = msb && (ans[NUM_WIDTH-2:0] == '0);
    magnitude = msb ? (~ans + ONE) : ans;
`ifdef ABS_SATURATE_EN
    if (mostNeg) begin
      magnitude = MAX_POS;
    end
`endif
  end

  // Data outputs only move on a valid operand so idle cycles leave the last result visible.
  always_comb begin
    valid_d = in_valid;
    abs_d   = abs_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    if (in_valid) begin
      abs_d  = magnitude;
      sign_d = msb;
      ovf_d  = mostNeg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      abs_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      abs_q   <= abs_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign abs_ans   = abs_q;
  assign sign_out  = sign_q;
  assign ovf       = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_abs_unit.sv
// tb_abs_unit: scoreboard bench for abs_unit with directed operands and hand-computed results.
// Honours ABS_SATURATE_EN for the expected most-negative magnitude.
module tb_abs_unit;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] absV;
    logic         signV;
    logic         ovfV;
  } expT;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inValid = 1'b0;
  logic [W-1:0] ans = '0;
  logic [W-1:0] absAns;
  logic         outValid;
  logic         signOut;
  logic         ovf;

  expT expQ[$];
  int  checks   = 0;
  int  failures = 0;
  logic monitorOn = 1'b0;

`ifdef ABS_SATURATE_EN
  localparam logic [W-1:0] MOST_NEG_MAG = 16'h7FFF;
`else
  localparam logic [W-1:0] MOST_NEG_MAG = 16'h8000;
`endif

  abs_unit #(.NUM_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .ans      (ans),
    .abs_ans  (absAns),
    .out_valid(outValid),
    .sign_out (signOut),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Drives one cycle's inputs on the falling edge and queues the result it should produce.
  task automatic applyStimulus(input logic valid, input logic [W-1:0] a, input logic doRst,
                               input logic [W-1:0] expAbs, input logic expSign, input logic expOvf);
    expT e;
    @(negedge clk);
    rst     = doRst;
    inValid = valid;
    ans     = a;
    if (valid && !doRst) begin
      e.absV  = expAbs;
      e.signV = expSign;
      e.ovfV  = expOvf;
      expQ.push_back(e);
    end
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] expAbs, input logic expValid,
                             input logic expSign, input logic expOvf);
    checks++;
    if (absAns !== expAbs || outValid !== expValid || signOut !== expSign || ovf !== expOvf) begin
      failures++;
      $display("[TB] FAIL %s: got abs=%h valid=%b sign=%b ovf=%b, want abs=%h valid=%b sign=%b ovf=%b",
               name, absAns, outValid, signOut, ovf, expAbs, expValid, expSign, expOvf);
    end
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (monitorOn && outValid === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_out: got abs=%h with no operand outstanding", absAns);
        end else begin
          e = expQ.pop_front();
          if (absAns !== e.absV || signOut !== e.signV || ovf !== e.ovfV) begin
            failures++;
            $display("[TB] FAIL result: got abs=%h sign=%b ovf=%b, want abs=%h sign=%b ovf=%b",
                     absAns, signOut, ovf, e.absV, e.signV, e.ovfV);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget;
    // Reset held for two edges, then released with no operand.
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h1234, 1'b0, '0, 1'b0, 1'b0);
    monitorOn = 1'b1;
    checkOutput("idle_after_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'h0F50, 1'b0, 16'h0F50, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hFF50, 1'b0, 16'h00B0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h8000, 1'b0, MOST_NEG_MAG, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h8001, 1'b0, 16'h7FFF, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hC000, 1'b0, 16'h4000, 1'b1, 1'b0);

    // Idle: result of 16'hC000 must stay on the data outputs.
    applyStimulus(1'b0, 16'h1111, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h2222, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("idle_hold", 16'h4000, 1'b0, 1'b1, 1'b0);

    applyStimulus(1'b1, 16'h8000, 1'b0, MOST_NEG_MAG, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("idle_hold_ovf", MOST_NEG_MAG, 1'b0, 1'b1, 1'b1);

    // Mid-stream reset: a valid operand alongside rst is discarded.
    applyStimulus(1'b1, 16'hFFF0, 1'b0, 16'h0010, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hFF50, 1'b1, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0F50, 1'b0, 16'h0F50, 1'b0, 1'b0);
    checkOutput("midstream_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, '0, 1'b0, 1'b0);

    budget = 20;
    while (expQ.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d results never appeared, want 0 outstanding", expQ.size());
    end
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
